// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = x - y, one bit per clock, LSB first.
// Subtraction is done as x + ~y + 1: the carry flop starts at 1 and the
// subtrahend bit is inverted on the fly. Results and flags are held until
// the next accepted start. The FSM state is exported on dbg_state.
//
// Handshake: start is accepted only in IDLE (busy=0, done=0). Starts seen
// in RUN or DONE are dropped. After acceptance, busy stays high for n
// cycles. done then pulses for one cycle, and d/b_out/overflow are valid
// from that cycle until the next accepted start.
module serial_subtractor #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  output logic [n-1:0] d,
  output logic         b_out,
  output logic         overflow,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  localparam int CW = (n > 2) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [n-1:0]  xs, ys, res;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          x_sign, y_sign;

  logic          y_inv, sum, carry_next, last_bit;

  // One full-adder slice on the current LSBs, with the subtrahend inverted.
  always_comb begin
    y_inv      = ~ys[0];
    sum        = xs[0] ^ y_inv ^ carry;
    carry_next = (xs[0] & y_inv) | (xs[0] & carry) | (y_inv & carry);
    last_bit   = (state == RUN) && (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. Starts outside IDLE are ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE_S;
      DONE_S:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand load, the serial shift, and result/flag capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      xs       <= '0;
      ys       <= '0;
      res      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      x_sign   <= 1'b0;
      y_sign   <= 1'b0;
      d        <= '0;
      b_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        xs     <= x;
        ys     <= y;
        x_sign <= x[n-1];
        y_sign <= y[n-1];
        carry  <= 1'b1;
        cnt    <= '0;
      end else if (state == RUN) begin
        xs    <= xs >> 1;
        ys    <= ys >> 1;
        res   <= {sum, res[n-1:1]};
        carry <= carry_next;
        cnt   <= cnt + 1'b1;
        if (last_bit) begin
          d        <= {sum, res[n-1:1]};
          b_out    <= ~carry_next;
          // sum is the result MSB in the last cycle.
          overflow <= (x_sign != y_sign) && (sum != x_sign);
        end
      end
    end
  end

  // Status outputs are decoded from the state register only.
  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE_S);
    dbg_state = state;
  end

endmodule
